// File: rtl/bcd_entry_pkg.sv
// Shared types and helpers for the BCD digit entry bank.
package bcd_entry_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic logic is_bcd(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_entry_bank_slot.sv
// One BCD digit register with a flag recording that it was loaded since the last clear.
module bcd_slot
    import bcd_entry_pkg::*;
(
    input  logic clock,
    input  logic resetL,
    input  logic clr,
    input  logic load_def,
    input  bcd_t def_val,
    input  logic we,
    input  bcd_t d,
    output bcd_t q,
    output logic written
);

    // Clear beats default load, which beats a write.
    always_ff @(posedge clock or negedge resetL) begin
        if (!resetL) begin
            q       <= '0;
            written <= 1'b0;
        end else if (clr) begin
            q       <= '0;
            written <= 1'b0;
        end else if (load_def) begin
            q       <= def_val;
            written <= 1'b1;
        end else if (we) begin
            q       <= d;
            written <= 1'b1;
        end
    end

endmodule

// File: rtl/bcd_entry_bank.sv
// Bank of BCD digit slots loaded one digit per cycle, by explicit selector or auto-advancing cursor.
module bcd_entry_bank
    import bcd_entry_pkg::*;
#(
    parameter int                     N_SLOTS = 9,
    parameter int                     SEL_W   = $clog2(N_SLOTS + 1),
    parameter logic [4*N_SLOTS-1:0]   DEFAULT = 36'h294753618
) (
    input  logic                      clock,
    input  logic                      resetL,
    input  bcd_t                      entry,
    input  logic [SEL_W-1:0]          selector,
    input  logic                      enableL,
    input  logic                      auto_advL,
    input  logic                      zeroL,
    input  logic                      set_defaultL,
    output bcd_t [N_SLOTS-1:0]        num,
    output logic [SEL_W-1:0]          cursor,
    output logic [N_SLOTS-1:0]        written,
    output logic                      full,
    output logic                      wrap,
    output logic                      err
);

    localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_SLOTS);

    logic               clr;
    logic               load_def;
    logic               attempt;
    logic               cursor_mode;
    logic [SEL_W-1:0]   target;
    logic               target_ok;
    logic               do_write;
    logic [N_SLOTS-1:0] we;

    assign clr         = !zeroL;
    assign load_def    = zeroL && !set_defaultL;
    assign attempt     = !enableL && zeroL && set_defaultL;
    assign cursor_mode = !auto_advL;
    // The cursor is always in range, so only a direct selector can miss.
    assign target      = cursor_mode ? cursor : selector;
    assign target_ok   = (target >= ONE) && (target <= LAST);
    assign do_write    = attempt && is_bcd(entry) && target_ok;

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        assign we[k] = do_write && (target == SEL_W'(k + 1));

        bcd_slot u_slot (
            .clock    (clock),
            .resetL   (resetL),
            .clr      (clr),
            .load_def (load_def),
            .def_val  (DEFAULT[4*k +: 4]),
            .we       (we[k]),
            .d        (entry),
            .q        (num[k]),
            .written  (written[k])
        );
    end

    always_ff @(posedge clock or negedge resetL) begin
        if (!resetL) begin
            cursor <= ONE;
            full   <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else if (clr) begin
            cursor <= ONE;
            full   <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else if (load_def) begin
            cursor <= ONE;
            full   <= 1'b1;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (attempt && !do_write) begin
                err <= 1'b1;
            end
            if (do_write) begin
                // Fold in this cycle's write so full rises with the completing bit.
                full <= &(written | we);
                if (cursor_mode) begin
                    if (cursor == LAST) begin
                        cursor <= ONE;
                        wrap   <= 1'b1;
                    end else begin
                        cursor <= cursor + ONE;
                    end
                end
            end
        end
    end

endmodule

// File: doc/bcd_entry_bank.md
# bcd_entry_bank

Parametrised bank of `N_SLOTS` BCD digit registers loaded one digit per cycle from a keypad-style entry path. It is the generalised successor of the nine-digit entry register: slot count and default pattern are parameters, and it adds BCD validation, a sticky error flag, an auto-advancing cursor mode, and per-slot written tracking. It sits between the keypad/switch decoder and the puzzle-check and display logic, which read all slots in parallel.

## Interface
- `N_SLOTS`, 9: number of digit slots, 1..15.
- `SEL_W`, `$clog2(N_SLOTS+1)`: selector/cursor width, derived; do not override.
- `DEFAULT`, 36'h294753618: packed default pattern, `4*N_SLOTS` bits. Slot k occupies bits [4k-1:4k-4]. The default value gives slots 1..9 = 8,1,6,3,5,7,4,9,2. It must be overridden whenever `N_SLOTS` != 9.
- `clock` input 1: sole clock, rising edge.
- `resetL` input 1: asynchronous, active-low reset.
- `entry` input 4: digit to store.
- `selector` input SEL_W: 1-based target slot in direct mode.
- `enableL` input 1: active-low write strobe, sampled each edge.
- `auto_advL` input 1: low selects cursor mode, high selects direct mode.
- `zeroL` input 1: active-low synchronous clear.
- `set_defaultL` input 1: active-low synchronous load of `DEFAULT`.
- `num` output N_SLOTS×4: slot values. `num[k-1]` is slot k.
- `cursor` output SEL_W: next slot written in cursor mode, 1..N_SLOTS.
- `written` output N_SLOTS: bit k-1 is set once slot k has been loaded since the last clear.
- `full` output 1: `written` is all ones. Registered.
- `wrap` output 1: one-cycle pulse when the cursor wraps from N_SLOTS to 1.
- `err` output 1: sticky rejected-write flag.

## Operation
- Reset (`resetL`=0, asynchronous): `num`=0, `cursor`=1, `written`=0, `full`=0, `wrap`=0, `err`=0.
- Per-edge priority: `zeroL`, then `set_defaultL`, then write. Only the highest active action occurs.
- `zeroL`=0: same values as reset, applied synchronously.
- `set_defaultL`=0 (with `zeroL`=1): `num`=`DEFAULT`, `written`=all ones, `full`=1, `cursor`=1, `err`=0, `wrap`=0.
- A write is attempted when `enableL`=0 and neither clear is active.
- Invalid entry (`entry`>9): nothing changes except `err` is set to 1.
- Direct mode (`auto_advL`=1):
  - Valid target (`selector` in 1..N_SLOTS): slot `selector` gets `entry` and its `written` bit is set. `cursor` is unchanged.
  - Invalid target (`selector` is 0 or >N_SLOTS): no write; `err` is set to 1.
- Cursor mode (`auto_advL`=0): slot `cursor` gets `entry`, its `written` bit is set, and `cursor` advances by 1.
  - At `cursor`=N_SLOTS the cursor returns to 1 and `wrap` pulses. With N_SLOTS=1, every valid write wraps.
- Rewriting an already-written slot is legal. The value is overwritten and `written` is unchanged.
- `err` clears only on reset, `zeroL` or `set_defaultL`.
- `wrap` is 0 in every cycle without a wrapping write.

## Timing
- All outputs are registered. An effect of edge n is visible after edge n, with no combinational input-to-output paths.
- Write latency is 1 cycle. `full` asserts in the same cycle as the `written` bit that completes it.
- Back-to-back writes are allowed every cycle, and cursor mode accepts one digit per cycle.
- Switching `auto_advL` between cycles is legal. The cursor keeps its value across direct-mode writes.
- Reset asserted mid-sequence takes effect immediately. After release, the first edge behaves as if starting from the reset state.

## Structure
- Package `bcd_entry_pkg`:
  - `typedef logic [3:0] bcd_t`
  - `localparam bcd_t BCD_MAX = 4'd9`
  - function `is_bcd(bcd_t)`
- Sub-module `bcd_slot`: one 4-bit digit register plus its written bit.
  - Inputs: `clock`, `resetL`, `clr`, `load_def`, `def_val`, `we`, `d`.
  - `bcd_entry_bank` instantiates `N_SLOTS` of them in a generate loop.
- Top level holds the write-decode logic, the cursor counter, and the `wrap`/`err`/`full` registers.

## Test plan
- Reset, then `set_defaultL`=0 for one cycle -> `num` = 8,1,6,3,5,7,4,9,2, `full`=1, `cursor`=1. Then `zeroL`=0 -> all slots 0, `written`=0, `full`=0.
- Direct mode, `selector`=3, `entry`=7, `enableL`=0 -> slot 3 = 7 and `written`=9'b000000100 on the next cycle. Then `selector`=0 and `selector`=10 -> no change, `err`=1.
- `entry`=4'hA in both modes -> no slot or cursor change, `err`=1. A following valid write still succeeds and `err` stays 1.
- Cursor mode, write 1..9 in 9 consecutive cycles:
  - slots read 1..9 and `full` rises after the 9th edge;
  - `wrap` pulses exactly once, after the 9th edge, and `cursor`=1.
  - A 10th write lands in slot 1.
- Simultaneous `zeroL`=0, `set_defaultL`=0 and `enableL`=0 -> the zero result wins. `set_defaultL`=0 together with a write -> the default wins.
- `N_SLOTS`=4 with a custom `DEFAULT`: cursor wraps 4->1, and `selector`=5 sets `err`. Assert `resetL` asynchronously between edges -> outputs clear before the next edge.
